// File: rtl/mio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mio_bus_arbiter
//  Description : Shares one memory/IO port between the multicycle CPU
//                controller and a DMA master. Fixed CPU priority with a
//                starvation guard that forces a DMA grant after a run of
//                CPU grants. Each access holds mem_en for MEM_LAT cycles
//                and returns a one-cycle ready pulse to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mio_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 2,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int c_LAT_W    = $clog2(MEM_LAT + 1);
  localparam int c_STARVE_W = $clog2(MAX_CPU_BURST + 1);

  localparam logic [c_LAT_W-1:0]    c_LAT_INIT   = c_LAT_W'(MEM_LAT);
  localparam logic [c_LAT_W-1:0]    c_LAT_LAST   = c_LAT_W'(1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(MAX_CPU_BURST);

  localparam logic [1:0] c_OWN_NONE = 2'b00;
  localparam logic [1:0] c_OWN_CPU  = 2'b01;
  localparam logic [1:0] c_OWN_DMA  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_LAT_W-1:0]      r_lat_cnt;
  logic [c_STARVE_W-1:0]   r_starve_cnt;

  logic                    w_any_req;
  logic                    w_dma_wins;

  // Grant decision: CPU has priority unless the DMA has waited through a full burst.
  assign w_any_req  = cpu_req | dma_req;
  assign w_dma_wins = dma_req & (~cpu_req | (r_starve_cnt == c_STARVE_MAX));

  // Arbitration FSM; every output is driven from this register block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      cpu_rdata    <= '0;
      cpu_ready    <= 1'b0;
      dma_rdata    <= '0;
      dma_ready    <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      owner        <= c_OWN_NONE;
      busy         <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse; it is only raised on the last access cycle.
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= ST_ACCESS;
            r_lat_cnt <= c_LAT_INIT;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            if (w_dma_wins) begin
              owner        <= c_OWN_DMA;
              mem_we       <= dma_we;
              mem_addr     <= dma_addr;
              mem_wdata    <= dma_wdata;
              r_starve_cnt <= '0;
            end else begin
              owner     <= c_OWN_CPU;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              // Count CPU grants only while the DMA is actually being held off.
              if (!dma_req) begin
                r_starve_cnt <= '0;
              end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (r_lat_cnt == c_LAT_LAST) begin
            r_state <= ST_DONE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            // Writes leave the owner's read register untouched.
            if (owner == c_OWN_CPU) begin
              cpu_ready <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end else begin
              dma_ready <= 1'b1;
              if (!mem_we) dma_rdata <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          owner   <= c_OWN_NONE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          owner   <= c_OWN_NONE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mio_bus_arbiter
//  Description : Directed scoreboard bench for mio_bus_arbiter. Stimulus
//                pushes the expected completion of each access; a monitor
//                pops and compares on every ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_bus_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        cpu_ready, dma_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic        busy;

  // Memory model: one fixed word, every other address returns a pattern of itself.
  assign mem_rdata = (mem_addr == 32'h0000_0100) ? 32'hDEAD_BEEF : (mem_addr ^ 32'h5A5A_0000);

  mio_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_CPU_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] own, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.own = own; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Caller is at a negedge. drop_early releases cpu_req in the first ACCESS cycle.
  task automatic cpu_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit drop_early);
    int n;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    if (drop_early) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(mem_en && owner == 2'b01) && n < 50);
      cpu_req = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 50);
    chk("cpu_ready_seen", 64'(cpu_ready), 64'(1));
    cpu_req = 1'b0;
  endtask

  task automatic dma_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dma_ready && n < 50);
    chk("dma_ready_seen", 64'(dma_ready), 64'(1));
    dma_req = 1'b0;
  endtask

  // Monitor: tracks the mem_* bus per access and checks each completion against the queue.
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_own;
  int          en_cnt    = 0;
  bit          stable_ok = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_cnt    = 0;
      stable_ok = 1'b1;
    end else begin
      if (mem_en) begin
        if (en_cnt == 0) begin
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_own = owner;
        end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                     mem_wdata !== cap_wdata || owner !== cap_own) begin
          stable_ok = 1'b0;
        end
        en_cnt++;
      end
      if (cpu_ready || dma_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 64'({dma_ready, cpu_ready}), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ready_source", 64'({dma_ready, cpu_ready}), 64'(e.own));
          chk("owner",        64'(cap_own),   64'(e.own));
          chk("mem_we",       64'(cap_we),    64'(e.we));
          chk("mem_addr",     64'(cap_addr),  64'(e.addr));
          chk("mem_wdata",    64'(cap_wdata), 64'(e.wdata));
          chk("rdata",        64'((e.own == 2'b01) ? cpu_rdata : dma_rdata), 64'(e.rdata));
          chk("mem_en_cycles", 64'(en_cnt),   64'(LAT));
          chk("bus_stable",   64'(stable_ok), 64'(1));
          chk("busy_in_done", 64'(busy),      64'(1));
          chk("mem_en_in_done", 64'(mem_en),  64'(0));
        end
        en_cnt    = 0;
        stable_ok = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_mem_en",    64'(mem_en),    64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_owner",     64'(owner),     64'(0));
    chk("rst_ready",     64'({dma_ready, cpu_ready}), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_dma_rdata", 64'(dma_rdata), 64'(0));

    // 1: plain CPU read
    push(2'b01, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    cpu_xfer(1'b0, 32'h100, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // 2: simultaneous requests, CPU first then DMA
    push(2'b01, 1'b0, 32'h104, 32'h0, 32'h5A5A_0104);
    push(2'b10, 1'b0, 32'h200, 32'h0, 32'h5A5A_0200);
    fork
      cpu_xfer(1'b0, 32'h104, 32'h0, 1'b0);
      dma_xfer(1'b0, 32'h200, 32'h0);
    join
    repeat (2) @(negedge clk);

    // 3: continuous CPU with DMA waiting -> four CPU grants, then DMA, then CPU
    push(2'b01, 1'b0, 32'h400, 32'h0, 32'h5A5A_0400);
    push(2'b01, 1'b0, 32'h404, 32'h0, 32'h5A5A_0404);
    push(2'b01, 1'b0, 32'h408, 32'h0, 32'h5A5A_0408);
    push(2'b01, 1'b0, 32'h40C, 32'h0, 32'h5A5A_040C);
    push(2'b10, 1'b0, 32'h300, 32'h0, 32'h5A5A_0300);
    push(2'b01, 1'b0, 32'h410, 32'h0, 32'h5A5A_0410);
    fork
      begin
        for (int i = 0; i < 5; i++) cpu_xfer(1'b0, 32'h400 + 32'(4 * i), 32'h0, 1'b0);
      end
      dma_xfer(1'b0, 32'h300, 32'h0);
    join
    repeat (2) @(negedge clk);

    // 4: DMA write; dma_rdata keeps its last read value
    push(2'b10, 1'b1, 32'h2000, 32'h0000_1234, 32'h5A5A_0300);
    dma_xfer(1'b1, 32'h2000, 32'h0000_1234);
    repeat (2) @(negedge clk);

    // 5: reset in the first ACCESS cycle of a CPU read
    cpu_we = 1'b0; cpu_addr = 32'h500; cpu_wdata = 32'h0; cpu_req = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_en && n < 20);
      chk("t5_grant", 64'(mem_en), 64'(1));
    end
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_mem_en",    64'(mem_en),    64'(0));
    chk("t5_busy",      64'(busy),      64'(0));
    chk("t5_ready",     64'({dma_ready, cpu_ready}), 64'(0));
    chk("t5_owner",     64'(owner),     64'(0));
    chk("t5_cpu_rdata", 64'(cpu_rdata), 64'(0));
    repeat (4) @(negedge clk);
    push(2'b01, 1'b0, 32'h104, 32'h0, 32'h5A5A_0104);
    cpu_xfer(1'b0, 32'h104, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // 6: cpu_req dropped during ACCESS still completes exactly once
    push(2'b01, 1'b0, 32'h600, 32'h0, 32'h5A5A_0600);
    cpu_xfer(1'b0, 32'h600, 32'h0, 1'b1);
    repeat (6) @(negedge clk);

    // CPU write keeps cpu_rdata at the last read value
    push(2'b01, 1'b1, 32'h700, 32'hCAFE_0001, 32'h5A5A_0600);
    cpu_xfer(1'b1, 32'h700, 32'hCAFE_0001, 1'b0);
    repeat (4) @(negedge clk);

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
